// File: rtl/ahbl_i2s_tx.sv
// AHB-Lite slave that streams stereo 16-bit frames from a CPU-filled FIFO
// out as an I2S master (SCK/WS/SD), with a FIFO low-water interrupt.
module ahbl_i2s_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HSEL,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        SCK,
  output logic        WS,
  output logic        SD,
  output logic        IRQ
);

  localparam int LW = FIFO_AW + 1;

  localparam logic [23:0] OFF_CTRL   = 24'h00;
  localparam logic [23:0] OFF_DIV    = 24'h04;
  localparam logic [23:0] OFF_DATA   = 24'h08;
  localparam logic [23:0] OFF_STATUS = 24'h0C;
  localparam logic [23:0] OFF_THRESH = 24'h10;

  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q, hsel_q;
  logic [2:0]  hsize_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      haddr_q  <= '0;
      htrans_q <= '0;
      hwrite_q <= 1'b0;
      hsel_q   <= 1'b0;
      hsize_q  <= '0;
    end else if (HREADY) begin
      haddr_q  <= HADDR;
      htrans_q <= HTRANS;
      hwrite_q <= HWRITE;
      hsel_q   <= HSEL;
      hsize_q  <= HSIZE;
    end
  end

  logic [23:0] off;
  logic        wr;
  logic        unused_ok;
  assign off       = haddr_q[23:0];
  assign wr        = htrans_q[1] & hsel_q & hwrite_q;
  assign unused_ok = ^{haddr_q[31:24], htrans_q[0], hsize_q};

  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  div_q, div_d;
  logic [6:0]  thresh_q, thresh_d;
  logic        underrun_q, underrun_d, overflow_q, overflow_d;
  logic [LW-1:0]      level_q, level_d;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic        empty, full, push_req, push, pop, load, underrun_set;
  logic [6:0]  level_ext;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign push_req  = wr && (off == OFF_DATA);
  assign push      = push_req && !full;
  assign pop       = load && !empty;
  assign underrun_set = load && empty;
  assign level_ext = 7'(level_q);

  always_comb begin
    ctrl_d     = ctrl_q;
    div_d      = div_q;
    thresh_d   = thresh_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (wr) begin
      case (off)
        OFF_CTRL:   ctrl_d   = HWDATA[1:0];
        OFF_DIV:    div_d    = HWDATA[7:0];
        OFF_THRESH: thresh_d = HWDATA[6:0];
        OFF_STATUS: begin
          if (HWDATA[2]) underrun_d = 1'b0;
          if (HWDATA[3]) overflow_d = 1'b0;
        end
        default: ;
      endcase
    end
    // A new event in the same cycle as a W1C wins, so no event is ever lost.
    if (underrun_set)     underrun_d = 1'b1;
    if (push_req && full) overflow_d = 1'b1;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wptr_q] <= HWDATA;
  end

  // Serializer: runs only while EN is set both now and in the value being written,
  // so clearing EN blanks the outputs at the same edge the register changes.
  logic        run, tick, sck_q, sck_d, ws_q, ws_d, sd_q, sd_d;
  logic [7:0]  presc_q, presc_d, div_act_q, div_act_d;
  logic [4:0]  s_q, s_d, s_next;
  logic [31:0] sh_q, sh_d, word;

  assign run    = ctrl_q[0] & ctrl_d[0];
  assign tick   = run && (presc_q == div_act_q);
  assign s_next = s_q + 5'd1;
  assign load   = tick && sck_q && (s_next == 5'd0);
  assign word   = empty ? 32'h0 : mem_q[rptr_q];

  always_comb begin
    presc_d   = presc_q;
    div_act_d = div_act_q;
    sck_d     = sck_q;
    s_d       = s_q;
    ws_d      = ws_q;
    sd_d      = sd_q;
    sh_d      = sh_q;
    if (!run) begin
      presc_d   = '0;
      div_act_d = div_q;
      sck_d     = 1'b0;
      s_d       = 5'd31;
      ws_d      = 1'b0;
      sd_d      = 1'b0;
      sh_d      = '0;
    end else if (tick) begin
      presc_d   = '0;
      div_act_d = div_q;
      sck_d     = !sck_q;
      if (sck_q) begin
        s_d  = s_next;
        ws_d = (s_next >= 5'd15) && (s_next <= 5'd30);
        if (s_next == 5'd0) begin
          sd_d = word[31];
          sh_d = {word[30:0], 1'b0};
        end else begin
          sd_d = sh_q[31];
          sh_d = {sh_q[30:0], 1'b0};
        end
      end
    end else begin
      presc_d = presc_q + 8'd1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl_q     <= '0;
      div_q      <= '0;
      thresh_q   <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      level_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      presc_q    <= '0;
      div_act_q  <= '0;
      sck_q      <= 1'b0;
      s_q        <= 5'd31;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      sh_q       <= '0;
      IRQ        <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      thresh_q   <= thresh_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      if (push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      presc_q    <= presc_d;
      div_act_q  <= div_act_d;
      sck_q      <= sck_d;
      s_q        <= s_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      sh_q       <= sh_d;
      IRQ        <= ctrl_q[1] & ctrl_q[0] & (level_ext <= thresh_q);
    end
  end

  assign SCK       = sck_q;
  assign WS        = ws_q;
  assign SD        = sd_q;
  assign HREADYOUT = 1'b1;

  always_comb begin
    HRDATA = 32'hBADDBEEF;
    case (off)
      OFF_CTRL:   HRDATA = {30'h0, ctrl_q};
      OFF_DIV:    HRDATA = {24'h0, div_q};
      OFF_DATA:   HRDATA = 32'h0;
      OFF_STATUS: HRDATA = {21'h0, level_ext, overflow_q, underrun_q, full, empty};
      OFF_THRESH: HRDATA = {25'h0, thresh_q};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahbl_i2s_tx.sv
// Self-checking bench for ahbl_i2s_tx: register table, serial scoreboard
// and hand-timed sequences for EN timing, IRQ, abort and reset.
module tb_ahbl_i2s_tx;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT, SCK, WS, SD, IRQ;

  always #5 HCLK = ~HCLK;

  ahbl_i2s_tx #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HSEL(HSEL),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .SCK(SCK), .WS(WS), .SD(SD), .IRQ(IRQ)
  );

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] expected;
    string       name;
  } vec_t;

  int          assertCount = 0;
  int          failCount = 0;
  int          framesChecked = 0;
  bit          enShadow = 1'b0;
  logic [31:0] expQ[$];
  vec_t        vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] e, input string n);
    vec_t v;
    v.isWrite = w; v.addr = a; v.data = d; v.expected = e; v.name = n;
    return v;
  endfunction

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    HADDR = addr; HTRANS = 2'b10; HWRITE = 1'b1; HSEL = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = data; HTRANS = 2'b00; HWRITE = 1'b0; HSEL = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    @(posedge HCLK); #1;
    HADDR = addr; HTRANS = 2'b10; HWRITE = 1'b0; HSEL = 1'b1;
    @(posedge HCLK); #1;
    data = HRDATA;
    HTRANS = 2'b00; HSEL = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, output logic [31:0] rd);
    rd = '0;
    if (v.isWrite) busWrite(v.addr, v.data);
    else           busRead(v.addr, rd);
  endtask

  // Pushes a word; the expected stream only grows when the FIFO has room.
  task automatic pushWord(input logic [31:0] w, input bit accepted);
    busWrite(32'h08, w);
    if (accepted) expQ.push_back(w);
  endtask

  task automatic setEnable(input logic [31:0] ctrl);
    busWrite(32'h00, ctrl);
    @(posedge HCLK); #1;
    enShadow = ctrl[0];
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (expQ.size() != 0 && t < 3000) begin
      @(posedge HCLK);
      t++;
    end
    checkOutput(name, 32'(t < 3000), 32'h1);
    repeat (140) @(posedge HCLK);
  endtask

  // Rebuilds each frame from SD/WS on SCK rises (sampled mid-cycle) and compares
  // it with the next expected word, or 0 when the scoreboard has run dry.
  task automatic monitorSerial();
    int          slot = 31;
    bit          prevSck = 1'b0;
    bit          haveWord = 1'b0;
    logic [31:0] curExp = '0, sdWord = '0, wsWord = '0;
    forever begin
      @(negedge HCLK);
      if (!enShadow) begin
        slot = 31; prevSck = 1'b0; haveWord = 1'b0;
      end else begin
        if (prevSck && !SCK) slot = (slot + 1) % 32;
        if (!prevSck && SCK) begin
          if (slot == 0) begin
            curExp = 32'h0;
            if (expQ.size() > 0) curExp = expQ.pop_front();
            haveWord = 1'b1; sdWord = '0; wsWord = '0;
          end
          if (haveWord) begin
            sdWord[31-slot] = SD;
            wsWord[31-slot] = WS;
            if (slot == 31) begin
              checkOutput("frameSD", sdWord, curExp);
              checkOutput("frameWS", wsWord, 32'h0001FFFE);
              framesChecked++;
              haveWord = 1'b0;
            end
          end
        end
        prevSck = SCK;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int base, firstRise, firstFall, secondRise, firstHigh, noisy;
    logic sdAtFall;

    HRESET = 1'b1; HADDR = '0; HTRANS = '0; HWRITE = 1'b0; HSIZE = 3'b010;
    HWDATA = '0; HSEL = 1'b0; HREADY = 1'b1;
    fork monitorSerial(); join_none

    vecs.push_back(mkVec(0, 32'h00, 0, 32'h0,        "rstCtrl"));
    vecs.push_back(mkVec(0, 32'h04, 0, 32'h0,        "rstDiv"));
    vecs.push_back(mkVec(0, 32'h0C, 0, 32'h1,        "rstStatus"));
    vecs.push_back(mkVec(0, 32'h10, 0, 32'h0,        "rstThresh"));
    vecs.push_back(mkVec(0, 32'h20, 0, 32'hBADDBEEF, "badOffset"));
    vecs.push_back(mkVec(0, 32'h08, 0, 32'h0,        "dataReadZero"));
    vecs.push_back(mkVec(1, 32'h00, 32'h3, 0,        "wrCtrl"));
    vecs.push_back(mkVec(1, 32'h04, 32'h05, 0,       "wrDiv"));
    vecs.push_back(mkVec(1, 32'h10, 32'h4, 0,        "wrThresh"));
    vecs.push_back(mkVec(0, 32'h00, 0, 32'h3,        "rbCtrl"));
    vecs.push_back(mkVec(0, 32'h04, 0, 32'h5,        "rbDiv"));
    vecs.push_back(mkVec(0, 32'h10, 0, 32'h4,        "rbThresh"));
    vecs.push_back(mkVec(1, 32'h00, 32'h0, 0,        "wrCtrlOff"));
    vecs.push_back(mkVec(1, 32'h0C, 32'hC, 0,        "clrSticky"));
    vecs.push_back(mkVec(0, 32'h0C, 0, 32'h1,        "statusClean"));
    vecs.push_back(mkVec(1, 32'h20, 32'hFFFF, 0,     "wrBadOffset"));
    vecs.push_back(mkVec(0, 32'h00, 0, 32'h0,        "ctrlIntact"));
    vecs.push_back(mkVec(0, 32'h04, 0, 32'h5,        "divIntact"));

    repeat (3) @(posedge HCLK); #1;
    checkOutput("rstSCK", 32'(SCK), 32'h0);
    checkOutput("rstWS", 32'(WS), 32'h0);
    checkOutput("rstSD", 32'(SD), 32'h0);
    checkOutput("rstIRQ", 32'(IRQ), 32'h0);
    checkOutput("rstHREADYOUT", 32'(HREADYOUT), 32'h1);
    checkOutput("rstHRDATA", HRDATA, 32'h0);
    HRESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], rd);
      if (!vecs[i].isWrite) checkOutput(vecs[i].name, rd, vecs[i].expected);
    end

    // Serial format and EN-to-SCK timing at DIV=1, then underrun frames.
    busWrite(32'h04, 32'h1);
    pushWord(32'hA5F00F5A, 1'b1);
    setEnable(32'h1);
    firstRise = -1; firstFall = -1; secondRise = -1; sdAtFall = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge HCLK); #1;
      if (firstRise < 0 && SCK) firstRise = k;
      else if (firstRise >= 0 && firstFall < 0 && !SCK) begin
        firstFall = k; sdAtFall = SD;
      end else if (firstFall >= 0 && secondRise < 0 && SCK) secondRise = k;
    end
    checkOutput("firstRise", 32'(firstRise), 32'd2);
    checkOutput("firstFall", 32'(firstFall), 32'd4);
    checkOutput("secondRise", 32'(secondRise), 32'd6);
    checkOutput("msbAtFirstFall", 32'(sdAtFall), 32'h1);
    base = framesChecked;
    repeat (300) @(posedge HCLK);
    checkOutput("framesFormat", 32'(framesChecked - base >= 1), 32'h1);
    setEnable(32'h0);
    busRead(32'h0C, rd);
    checkOutput("underrunSet", rd, 32'h5);
    busWrite(32'h0C, 32'h4);
    busRead(32'h0C, rd);
    checkOutput("underrunClr", rd, 32'h1);

    // Overflow: 17 pushes into a 16-deep FIFO, then stream at DIV=0.
    busWrite(32'h04, 32'h0);
    for (int i = 0; i < 17; i++) pushWord((i + 1) * 32'h01234567 ^ 32'h80000001, i < 16);
    busRead(32'h0C, rd);
    checkOutput("fullOverflow", rd, 32'h10A);
    setEnable(32'h1);
    base = framesChecked;
    drain("drainOverflow");
    checkOutput("framesOverflow", 32'(framesChecked - base >= 16), 32'h1);
    setEnable(32'h0);
    busWrite(32'h0C, 32'hC);
    busRead(32'h0C, rd);
    checkOutput("statusAfterOvf", rd, 32'h1);

    // IRQ: level 4 -> 2 after the second pop, IRQ one cycle later.
    busWrite(32'h04, 32'h1);
    for (int i = 0; i < 4; i++) pushWord(32'h11110000 + 32'(i * 32'h0F0F), 1'b1);
    busWrite(32'h10, 32'h2);
    setEnable(32'h3);
    firstHigh = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge HCLK); #1;
      if (IRQ && firstHigh < 0) firstHigh = k;
    end
    checkOutput("irqRiseCycle", 32'(firstHigh), 32'd133);
    busWrite(32'h00, 32'h1);
    @(posedge HCLK); #1;
    checkOutput("irqBeforeClr", 32'(IRQ), 32'h1);
    @(posedge HCLK); #1;
    checkOutput("irqAfterClr", 32'(IRQ), 32'h0);
    drain("drainIrq");
    setEnable(32'h0);
    busWrite(32'h0C, 32'hC);
    busRead(32'h0C, rd);
    checkOutput("statusAfterIrq", rd, 32'h1);

    // Abort in slot 10 (SCK would be rising), then resume with the next word.
    pushWord(32'hDEADBEEF, 1'b1);
    pushWord(32'h0F1E2D3C, 1'b1);
    pushWord(32'hC3A55A3C, 1'b1);
    setEnable(32'h1);
    repeat (43) @(posedge HCLK);
    busWrite(32'h00, 32'h0);
    @(posedge HCLK); #1;
    checkOutput("abortSCK", 32'(SCK), 32'h0);
    checkOutput("abortWS", 32'(WS), 32'h0);
    checkOutput("abortSD", 32'(SD), 32'h0);
    enShadow = 1'b0;
    noisy = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge HCLK); #1;
      if (SCK || WS || SD) noisy++;
    end
    checkOutput("abortQuiet", 32'(noisy), 32'h0);
    busRead(32'h0C, rd);
    checkOutput("abortLevel", rd, 32'h20);
    setEnable(32'h1);
    base = framesChecked;
    drain("drainAbort");
    checkOutput("framesResume", 32'(framesChecked - base >= 2), 32'h1);
    setEnable(32'h0);
    busWrite(32'h0C, 32'hC);

    // Reset mid-frame while SCK is high.
    pushWord(32'h12345678, 1'b1);
    setEnable(32'h1);
    repeat (30) @(posedge HCLK); #1;
    HRESET = 1'b1;
    #1;
    checkOutput("midRstSCK", 32'(SCK), 32'h0);
    checkOutput("midRstSD", 32'(SD), 32'h0);
    checkOutput("midRstWS", 32'(WS), 32'h0);
    enShadow = 1'b0;
    expQ.delete();
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    busRead(32'h0C, rd);
    checkOutput("midRstStatus", rd, 32'h1);
    busRead(32'h00, rd);
    checkOutput("midRstCtrl", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ahbl_i2s_tx.md
# ahbl_i2s_tx

AHB-Lite slave I2S master transmitter that streams stereo 16-bit audio from a CPU-filled FIFO to an external DAC or amplifier. It is the playback counterpart of the I2S microphone receiver and sits on the same AHB-Lite bus. It generates SCK, WS and SD from HCLK through a programmable prescaler. It raises a level-sensitive IRQ when the FIFO drains to a programmable threshold.

## Interface
- FIFO_DEPTH, 16, number of 32-bit frame words buffered; power of two, 4..64
- FIFO_AW, 4, log2(FIFO_DEPTH)
- HCLK  in  1  system clock; all logic on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HADDR  in  32  address; offset decoded from [23:0]
- HTRANS  in  2  transfer type; bit 1 marks active transfer
- HWRITE  in  1  write strobe
- HSIZE  in  3  captured, unused (32-bit accesses only)
- HWDATA  in  32  write data (data phase)
- HSEL  in  1  slave select
- HREADY  in  1  bus ready; address phase captured when high
- HRDATA  out  32  read data
- HREADYOUT  out  1  tied 1 (zero wait states)
- SCK  out  1  I2S bit clock
- WS  out  1  word select; 0 = left, 1 = right
- SD  out  1  serial data, MSB first
- IRQ  out  1  FIFO low-water interrupt

## Operation
- Address-phase signals (HADDR, HTRANS, HWRITE, HSEL, HSIZE) are registered when HREADY=1. Write = HTRANS_d[1]&HSEL_d&HWRITE_d. Read = the same terms with !HWRITE_d.
- Registers:
  - 0x00 CTRL, RW: [0] EN, [1] IRQ_EN.
  - 0x04 PRESCALE, RW: [7:0] DIV.
  - 0x08 DATA, WO: one write pushes one frame word, {left[31:16], right[15:0]}. Reading 0x08 returns 0.
  - 0x0C STATUS: [0] empty, [1] full, [2] UNDERRUN sticky, [3] OVERFLOW sticky, [10:4] level. Writing 1 to bit 2 or bit 3 clears that bit; other bits are read-only.
  - 0x10 THRESH, RW: [6:0].
  - Any other offset reads 0xBADDBEEF; writes to it are ignored.
- Reset values: CTRL=0, DIV=0, THRESH=0, FIFO empty, sticky bits 0.
- FIFO push:
  - A push is accepted only when !full.
  - A push while full is dropped and sets OVERFLOW. This holds even if a pop occurs in the same cycle.
  - Simultaneous accepted push and pop leave the level unchanged.
- Serializer, active only when EN=1:
  - A prescaler counts 0..DIV; at terminal count SCK toggles.
  - On each SCK falling toggle, slot counter s advances modulo 32 and SD/WS update.
  - Entering s=0, the FIFO head is popped into a 32-bit shift register. If the FIFO is empty, 0 is loaded and UNDERRUN is set.
  - SD in slot s = word[31-s].
  - WS=1 for s in 15..30 and 0 otherwise, so WS leads each channel MSB by one slot (I2S format).
- EN=0 holds the prescaler at 0, s at 31, and SCK/WS/SD at 0; the FIFO content is retained. Clearing EN mid-frame aborts the frame immediately; no pop occurs and the partial word is discarded.
- A DIV write takes effect at the next prescaler wrap.
- IRQ (registered) = IRQ_EN & EN & (level <= THRESH).

## Timing
- Reset, asynchronous: SCK=WS=SD=IRQ=0. HRDATA follows the decode of HADDR_d=0, i.e. CTRL=0. HREADYOUT=1 always.
- Register write is visible on HRDATA in the cycle after its data phase.
- The FIFO level updates 1 cycle after the DATA data phase.
- SCK half-period = DIV+1 HCLK cycles; frame = 64·(DIV+1) HCLK.
- After EN rises:
  - The first SCK rise occurs DIV+1 cycles later.
  - The first fall, which performs the pop and drives the MSB, occurs 2·(DIV+1) cycles later.
- SD and WS change only in the cycle SCK falls, so the receiver samples them stable on SCK rising.
- IRQ lags a level change by 1 cycle.
- HRESET asserted mid-frame forces all outputs low immediately and empties the FIFO.

## Test plan
- Reset and read-back:
  - Stimulus: assert HRESET, then read 0x00/0x04/0x0C/0x10/0x20.
  - Required: 0, 0, 0x1 (empty), 0, 0xBADDBEEF.
  - Stimulus: write CTRL=3, DIV=0x05, THRESH=4 and read back.
  - Required: the same values.
- Serial format:
  - Stimulus: DIV=1; push 0xA5F0_0F5A; set EN=1.
  - Required: SCK period 4 HCLK. First fall at cycle 4 after EN. SD bit sequence equals 0xA5F00F5A MSB first. WS rises at slot 15 and falls at slot 31.
- Underrun:
  - Stimulus: EN=1 with an empty FIFO.
  - Required: SD stays 0 and UNDERRUN=1. Writing 0x4 to STATUS clears it.
- Overflow and full:
  - Stimulus: with EN=0, push 17 words at FIFO_DEPTH=16.
  - Required: full=1, level=16, OVERFLOW=1. Enabling EN then outputs exactly words 1..16.
- IRQ:
  - Stimulus: THRESH=2, IRQ_EN=1, EN=1, 4 words pushed.
  - Required: IRQ stays low until the second pop makes the level 2; IRQ goes high one cycle later.
  - Stimulus: clear IRQ_EN.
  - Required: IRQ goes low in the next cycle.
- Mid-frame abort:
  - Stimulus: clear EN at slot 10.
  - Required: SCK/WS/SD go to 0 within 1 cycle and the level is unchanged. Re-enabling resumes with the next FIFO word at slot 0.
